sdr_arbiter: RTL and testbench

Parametrised N-channel SDRAM request arbiter using toggle req/ack handshakes on both sides. It sits between the core's SDRAM clients (CPU, tilemap, sprite mux, audio, ROM loader, …) and the single host SDRAM port. It replaces the hard-wired five-channel fixed-priority mux in the sim top, adding:
- channel-count, width and priority-mode parameters;
- run-time round-robin arbitration;
- a per-channel grant mask.

---
 rtl/sdr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_sdr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_arbiter.sv
// N-channel SDRAM request arbiter, toggle req/ack on both client and host sides.
// Optional per-channel grant counters are built when SDR_ARB_STATS_EN is defined.
module sdr_arbiter #(
  parameter int NUM_CH = 5,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 64,
  parameter int BE_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prio_rr,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH-1:0]        ch_req,
  output logic [NUM_CH-1:0]        ch_ack,
  input  logic [NUM_CH-1:0]        ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  output logic [NUM_CH*DATA_W-1:0] ch_q,
  output logic                     sdr_req,
  input  logic                     sdr_ack,
  output logic                     sdr_rw,
  output logic [ADDR_W-1:0]        sdr_addr,
  output logic [DATA_W-1:0]        sdr_data,
  output logic [BE_W-1:0]          sdr_be,
  input  logic [DATA_W-1:0]        sdr_q,
  output logic [NUM_CH*16-1:0]     grant_cnt
);

  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]   NUM_CH_X = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          active_q, active_d;
  logic [CH_W-1:0]          last_q, last_d;
  logic [NUM_CH-1:0]        ack_q, ack_d;
  logic [NUM_CH*DATA_W-1:0] q_q, q_d;
  logic                     req_q, req_d;
  logic                     rw_q, rw_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [BE_W-1:0]          be_q, be_d;

  logic [NUM_CH-1:0] eligible;
  logic [CH_W:0]     start, cand;
  logic              found;
  logic [CH_W-1:0]   win;
  logic              grant;

  // Circular search from start; fixed priority is simply start = 0.
  always_comb begin
    eligible = (ch_req ^ ack_q) & ch_mask;
    start    = prio_rr ? ({1'b0, last_q} + (CH_W+1)'(1)) : '0;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = start + (CH_W+1)'(k);
      if (cand >= NUM_CH_X) cand = cand - NUM_CH_X;
      if (!found && eligible[cand[CH_W-1:0]]) begin
        found = 1'b1;
        win   = cand[CH_W-1:0];
      end
    end
  end

  assign grant = (state_q == S_IDLE) && found;

  // NOTE: every _d starts from its _q so no path through this block leaves a latch.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    last_d   = last_q;
    ack_d    = ack_q;
    q_d      = q_q;
    req_d    = req_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_d    = ~req_q;
          rw_d     = ch_rw[win];
          addr_d   = ch_addr[int'(win)*ADDR_W +: ADDR_W];
          data_d   = ch_data[int'(win)*DATA_W +: DATA_W];
          be_d     = ch_be[int'(win)*BE_W +: BE_W];
          active_d = win;
          last_d   = win;
          state_d  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (req_q == sdr_ack) begin
          ack_d[active_q] = ~ack_q[active_q];
          if (rw_q) q_d[int'(active_q)*DATA_W +: DATA_W] = sdr_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: ch_q is a bank of per-channel flops, not a RAM, so it clears on reset like the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      last_q   <= LAST_CH;
      ack_q    <= '0;
      q_q      <= '0;
      req_q    <= 1'b0;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      last_q   <= last_d;
      ack_q    <= ack_d;
      q_q      <= q_d;
      req_q    <= req_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
    end
  end

  assign ch_ack   = ack_q;
  assign ch_q     = q_q;
  assign sdr_req  = req_q;
  assign sdr_rw   = rw_q;
  assign sdr_addr = addr_q;
  assign sdr_data = data_q;
  assign sdr_be   = be_q;

`ifdef SDR_ARB_STATS_EN
  logic [NUM_CH*16-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant && (cnt_q[int'(win)*16 +: 16] != 16'hFFFF))
      cnt_d[int'(win)*16 +: 16] = cnt_q[int'(win)*16 +: 16] + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_sdr_arbiter.sv
// Randomised bench for sdr_arbiter: transaction-level reference model, random host
// latency, directed scenarios with literal expectations, and a per-cycle compare.
module tb_sdr_arbiter;

  localparam int N  = 5;
  localparam int AW = 27;
  localparam int DW = 64;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            prio_rr = 1'b0;
  logic [N-1:0]    ch_mask = '1;
  logic [N-1:0]    ch_req = '0;
  logic [N-1:0]    ch_rw = '1;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N*DW-1:0] ch_data = '0;
  logic [N*BW-1:0] ch_be = '0;
  logic            sdr_ack = 1'b0;
  logic [DW-1:0]   sdr_q = '0;

  logic [N-1:0]    ch_ack;
  logic [N*DW-1:0] ch_q;
  logic            sdr_req;
  logic            sdr_rw;
  logic [AW-1:0]   sdr_addr;
  logic [DW-1:0]   sdr_data;
  logic [BW-1:0]   sdr_be;
  logic [N*16-1:0] grant_cnt;

  sdr_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
    .clk(clk), .reset(reset), .prio_rr(prio_rr), .ch_mask(ch_mask),
    .ch_req(ch_req), .ch_ack(ch_ack), .ch_rw(ch_rw), .ch_addr(ch_addr),
    .ch_data(ch_data), .ch_be(ch_be), .ch_q(ch_q), .sdr_req(sdr_req),
    .sdr_ack(sdr_ack), .sdr_rw(sdr_rw), .sdr_addr(sdr_addr), .sdr_data(sdr_data),
    .sdr_be(sdr_be), .sdr_q(sdr_q), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: what the arbiter must look like after each edge.
  bit            m_busy;
  int            m_act;
  int            m_last;
  bit [N-1:0]    m_ack;
  logic [DW-1:0] m_q [N];
  bit            m_sreq;
  bit            m_srw;
  logic [AW-1:0] m_saddr;
  logic [DW-1:0] m_sdata;
  logic [BW-1:0] m_sbe;
  int            m_cnt [N];
  int            m_done = 0;

  // Host model and grant log recovered from DUT outputs (addr low nibble = channel).
  int            host_min = 0;
  int            host_max = 2;
  bit            host_fixed = 1'b0;
  logic [DW-1:0] host_q = '0;
  int            h_cnt = 0;
  logic          prev_sreq = 1'b0;
  int            dut_grants [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_act   = 0;
    m_last  = N - 1;
    m_ack   = '0;
    m_sreq  = 1'b0;
    m_srw   = 1'b1;
    m_saddr = '0;
    m_sdata = '0;
    m_sbe   = '0;
    for (int i = 0; i < N; i++) begin
      m_q[i]   = '0;
      m_cnt[i] = 0;
    end
  endfunction

  function automatic int dut_g(input int k);
    return (k < dut_grants.size()) ? dut_grants[k] : -1;
  endfunction

  function automatic bit model_pending();
    return |((ch_req ^ m_ack) & ch_mask);
  endfunction

  task automatic model_step();
    int w;
    w = -1;
    if (reset) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = prio_rr ? (m_last + 1 + k) % N : k;
        if (w < 0 && ch_req[c] != m_ack[c] && ch_mask[c]) w = c;
      end
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_act   = w;
        m_last  = w;
        m_sreq  = ~m_sreq;
        m_srw   = ch_rw[w];
        m_saddr = ch_addr[w*AW +: AW];
        m_sdata = ch_data[w*DW +: DW];
        m_sbe   = ch_be[w*BW +: BW];
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end
    end else if (m_sreq == sdr_ack) begin
      m_ack[m_act] = ~m_ack[m_act];
      if (m_srw) m_q[m_act] = sdr_q;
      m_busy = 1'b0;
      m_done++;
    end
  endtask

  task automatic compare();
    logic [N*DW-1:0] eq;
    logic [N*16-1:0] ec;
    for (int i = 0; i < N; i++) begin
      eq[i*DW +: DW] = m_q[i];
`ifdef SDR_ARB_STATS_EN
      ec[i*16 +: 16] = 16'(m_cnt[i]);
`else
      ec[i*16 +: 16] = 16'h0;
`endif
    end
    check("sdr_req", sdr_req, m_sreq);
    check("sdr_cmd", {sdr_rw, sdr_addr, sdr_data, sdr_be}, {m_srw, m_saddr, m_sdata, m_sbe});
    check("ch_ack", ch_ack, m_ack);
    check("ch_q", ch_q, eq);
    check("grant_cnt", grant_cnt, ec);
    if (sdr_req !== prev_sreq) dut_grants.push_back(int'(sdr_addr[3:0]));
    prev_sreq = sdr_req;
  endtask

  task automatic host_step();
    if (reset) begin
      sdr_ack = 1'b0;
      h_cnt   = 0;
    end else if (sdr_ack != sdr_req) begin
      if (h_cnt <= 0) begin
        sdr_ack = sdr_req;
        sdr_q   = host_fixed ? host_q : {$urandom, $urandom};
      end else begin
        h_cnt--;
      end
    end else begin
      h_cnt = $urandom_range(host_max, host_min);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    host_step();
  endtask

  task automatic request(input int i, input bit rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BW-1:0] be);
    ch_rw[i]            = rw;
    ch_addr[i*AW +: AW] = addr;
    ch_data[i*DW +: DW] = data;
    ch_be[i*BW +: BW]   = be;
    ch_req[i]           = ~ch_req[i];
  endtask

  task automatic rand_request(input int i);
    request(i, 1'($urandom_range(1, 0)), AW'({$urandom, 4'(i)}), {$urandom, $urandom}, BW'($urandom));
  endtask

  task automatic wait_done(input int target, input int budget);
    while (m_done < target && budget > 0) begin
      tick();
      budget--;
    end
    check("wait_done", m_done >= target, 1'b1);
  endtask

  task automatic drain(input int budget);
    while ((m_busy || model_pending()) && budget > 0) begin
      tick();
      budget--;
    end
    check("drain", m_busy || model_pending(), 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sdr_req"}, sdr_req, 1'b0);
    check({tag, "_sdr_cmd"}, {sdr_rw, sdr_addr, sdr_data, sdr_be}, {1'b1, 99'h0});
    check({tag, "_ch_ack"}, ch_ack, 5'b00000);
    check({tag, "_ch_q"}, ch_q, 512'h0);
    check({tag, "_grant_cnt"}, grant_cnt, 512'h0);
  endtask

  initial begin
    int base;
    int n0;
    bit stop;
    int budget;
    logic [N*DW-1:0] exp_q;

    model_reset();
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;

    // Single read on ch2
    host_min = 4; host_max = 4; host_fixed = 1'b1; host_q = 64'hDEADBEEF_CAFEF00D;
    request(2, 1'b1, 27'h123456, 64'h0, 8'hFF);
    wait_done(m_done + 1, 100);
    check("single_addr", sdr_addr, 27'h123456);
    check("single_rw", sdr_rw, 1'b1);
    check("single_ack", ch_ack, 5'b00100);
    exp_q = '0;
    exp_q[2*DW +: DW] = 64'hDEADBEEF_CAFEF00D;
    check("single_q", ch_q, exp_q);

    // Fixed priority among ch1, ch3, ch4
    prio_rr = 1'b0; host_min = 1; host_max = 3; host_q = 64'h12345678_9ABCDEF0;
    base = dut_grants.size();
    request(1, 1'b1, 27'h0000_101, 64'h0, 8'hFF);
    request(3, 1'b1, 27'h0000_303, 64'h0, 8'hFF);
    request(4, 1'b1, 27'h0000_404, 64'h0, 8'hFF);
    wait_done(m_done + 3, 200);
    check("fixed_g0", dut_g(base), 1);
    check("fixed_g1", dut_g(base + 1), 3);
    check("fixed_g2", dut_g(base + 2), 4);
    check("fixed_q4", ch_q[4*DW +: DW], 64'h12345678_9ABCDEF0);

    // Write on ch4 leaves its read data untouched
    request(4, 1'b0, 27'h0000_504, 64'hABCD, 8'h03);
    wait_done(m_done + 1, 100);
    check("write_rw", sdr_rw, 1'b0);
    check("write_be", sdr_be, 8'h03);
    check("write_data", sdr_data, 64'hABCD);
    check("write_q4", ch_q[4*DW +: DW], 64'h12345678_9ABCDEF0);

    // Mask: ch0 held off while ch3 is served, then granted on the next idle edge
    ch_mask = 5'b11110;
    base = dut_grants.size();
    request(0, 1'b1, 27'h0000_600, 64'h0, 8'hFF);
    request(3, 1'b1, 27'h0000_703, 64'h0, 8'hFF);
    wait_done(m_done + 1, 100);
    repeat (10) tick();
    check("mask_g0", dut_g(base), 3);
    check("mask_count", dut_grants.size(), base + 1);
    check("mask_ack0", ch_ack[0], 1'b0);
    ch_mask = '1;
    n0 = dut_grants.size();
    tick();
    check("unmask_count", dut_grants.size(), n0 + 1);
    check("unmask_g", dut_g(n0), 0);
    wait_done(m_done + 1, 100);

    // Reset while a transaction is in flight
    host_min = 10; host_max = 10;
    request(2, 1'b1, 27'h0000_802, 64'h0, 8'hFF);
    repeat (3) tick();
    #2;
    reset     = 1'b1;
    ch_req    = '0;
    sdr_ack   = 1'b0;
    prev_sreq = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    reset = 1'b0;

    // Round-robin with every channel re-requesting continuously
    prio_rr = 1'b1; host_min = 0; host_max = 2; host_fixed = 1'b0;
    for (int i = 0; i < N; i++) rand_request(i);
    base = dut_grants.size();
    stop = 1'b0;
    budget = 2000;
    while (!stop && budget > 0) begin
      tick();
      budget--;
      if (dut_grants.size() - base >= 50) begin
        stop = 1'b1;
`ifdef SDR_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("rr_cnt", grant_cnt[i*16 +: 16], 16'd10);
`else
        check("rr_cnt", grant_cnt, 80'h0);
`endif
      end else begin
        for (int i = 0; i < N; i++) if (ch_req[i] == m_ack[i]) rand_request(i);
      end
    end
    check("rr_reached_50", stop, 1'b1);
    for (int k = 0; k < 50; k++) check("rr_order", dut_g(base + k), k % N);
    drain(300);

    // Random traffic: masks, mode flips, host latency all vary
    host_max = 5;
    for (int t = 0; t < 3000; t++) begin
      tick();
      if ($urandom_range(49, 0) == 0) prio_rr = ~prio_rr;
      if ($urandom_range(19, 0) == 0) ch_mask = N'($urandom);
      for (int i = 0; i < N; i++)
        if (ch_req[i] == m_ack[i] && $urandom_range(3, 0) == 0) rand_request(i);
    end
    ch_mask = '1;
    drain(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
